// File: rtl/pat_video_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : pat_video_timing_gen
// Brief    : Triggered raster timing generator; emits one frame of registered
//            h_sync / v_sync / de plus pixel coordinates per accepted trigger.
//            Define VTG_FREE_RUN_EN for continuous back-to-back frames.
// Revision : 1.0 - initial release
// ============================================================================
module pat_video_timing_gen #(
    parameter int unsigned H_ACTIVE = 1920,
    parameter int unsigned H_FP     = 88,
    parameter int unsigned H_SYNC   = 44,
    parameter int unsigned H_BP     = 148,
    parameter int unsigned V_ACTIVE = 1080,
    parameter int unsigned V_FP     = 4,
    parameter int unsigned V_SYNC   = 5,
    parameter int unsigned V_BP     = 36
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_trig,
    input  logic        abort,
    output logic        frame_busy,
    output logic        h_sync_out,
    output logic        v_sync_out,
    output logic        de_out,
    output logic [11:0] pix_x,
    output logic [10:0] pix_y,
    output logic        frame_done,
    output logic [15:0] frame_cnt
);

    localparam logic [11:0] c_h_active     = 12'(H_ACTIVE);
    localparam logic [11:0] c_h_sync_start = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] c_h_sync_end   = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] c_h_last       = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [10:0] c_v_active     = 11'(V_ACTIVE);
    localparam logic [10:0] c_v_sync_start = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] c_v_sync_end   = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [10:0] c_v_last       = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

    localparam logic [0:0] c_st_idle = 1'b0;
    localparam logic [0:0] c_st_run  = 1'b1;

    logic [0:0]  r_state;
    logic [0:0]  w_state_nxt;
    logic [11:0] r_h_cnt;
    logic [11:0] w_h_nxt;
    logic [10:0] r_v_cnt;
    logic [10:0] w_v_nxt;
    logic        w_last;
    logic        w_frame_end;
    logic        w_run;
    logic        w_de;
    logic        w_h_sync;
    logic        w_v_sync;

    logic        r_busy;
    logic        r_h_sync;
    logic        r_v_sync;
    logic        r_de;
    logic [11:0] r_pix_x;
    logic [10:0] r_pix_y;
    logic        r_end_d;
    logic        r_frame_done;
    logic [15:0] r_frame_cnt;

    assign w_run    = (r_state == c_st_run);
    assign w_last   = (r_h_cnt == c_h_last) && (r_v_cnt == c_v_last);
    assign w_de     = (r_h_cnt < c_h_active) && (r_v_cnt < c_v_active);
    assign w_h_sync = (r_h_cnt >= c_h_sync_start) && (r_h_cnt < c_h_sync_end);
    assign w_v_sync = (r_v_cnt >= c_v_sync_start) && (r_v_cnt < c_v_sync_end);

    always_comb begin
        w_state_nxt = r_state;
        w_h_nxt     = r_h_cnt;
        w_v_nxt     = r_v_cnt;
        w_frame_end = 1'b0;
        case (r_state)
            c_st_idle: begin
                w_h_nxt = '0;
                w_v_nxt = '0;
                if (frame_trig && !abort) begin
                    w_state_nxt = c_st_run;
                end
            end
            c_st_run: begin
                if (abort) begin
                    w_state_nxt = c_st_idle;
                    w_h_nxt     = '0;
                    w_v_nxt     = '0;
                end else if (w_last) begin
                    w_frame_end = 1'b1;
                    w_h_nxt     = '0;
                    w_v_nxt     = '0;
`ifdef VTG_FREE_RUN_EN
                    w_state_nxt = c_st_run;
`else
                    w_state_nxt = c_st_idle;
`endif
                end else if (r_h_cnt == c_h_last) begin
                    w_h_nxt = '0;
                    w_v_nxt = r_v_cnt + 11'd1;
                end else begin
                    w_h_nxt = r_h_cnt + 12'd1;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
                w_h_nxt     = '0;
                w_v_nxt     = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_h_cnt <= w_h_nxt;
            r_v_cnt <= w_v_nxt;
        end
    end

    // Outputs trail the counters by one cycle; frame_done trails the last
    // position by two so it lands on the first cycle after the frame ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy       <= 1'b0;
            r_h_sync     <= 1'b0;
            r_v_sync     <= 1'b0;
            r_de         <= 1'b0;
            r_pix_x      <= '0;
            r_pix_y      <= '0;
            r_end_d      <= 1'b0;
            r_frame_done <= 1'b0;
            r_frame_cnt  <= '0;
        end else begin
            r_busy       <= w_run;
            r_h_sync     <= w_run && w_h_sync;
            r_v_sync     <= w_run && w_v_sync;
            r_de         <= w_run && w_de;
            r_pix_x      <= w_run ? r_h_cnt : '0;
            r_pix_y      <= w_run ? r_v_cnt : '0;
            r_end_d      <= w_frame_end;
            r_frame_done <= r_end_d;
            if (r_end_d) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
        end
    end

    assign frame_busy = r_busy;
    assign h_sync_out = r_h_sync;
    assign v_sync_out = r_v_sync;
    assign de_out     = r_de;
    assign pix_x      = r_pix_x;
    assign pix_y      = r_pix_y;
    assign frame_done = r_frame_done;
    assign frame_cnt  = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pat_video_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_pat_video_timing_gen
// Brief    : Self-checking bench for pat_video_timing_gen using a small raster
//            (14x7) and an arithmetic position-to-output reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pat_video_timing_gen;

    localparam int HA = 8;
    localparam int HF = 2;
    localparam int HS = 2;
    localparam int HB = 2;
    localparam int VA = 4;
    localparam int VF = 1;
    localparam int VS = 1;
    localparam int VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int N  = HT * VT;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        frame_trig;
    logic        abort;
    logic        frame_busy;
    logic        h_sync_out;
    logic        v_sync_out;
    logic        de_out;
    logic [11:0] pix_x;
    logic [10:0] pix_y;
    logic        frame_done;
    logic [15:0] frame_cnt;

    logic [26:0] obs;
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] exp_cnt  = '0;

    pat_video_timing_gen #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_trig (frame_trig),
        .abort      (abort),
        .frame_busy (frame_busy),
        .h_sync_out (h_sync_out),
        .v_sync_out (v_sync_out),
        .de_out     (de_out),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .frame_done (frame_done),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk = ~clk;

    assign obs = {frame_busy, h_sync_out, v_sync_out, de_out, pix_x, pix_y};

    // Expected {busy,hs,vs,de,x,y} while the frame shows raster position k.
    function automatic logic [26:0] exp_run(input int k);
        int x;
        int y;
        x = k % HT;
        y = k / HT;
        exp_run = {1'b1, (x >= HA + HF && x < HA + HF + HS),
                   (y >= VA + VF && y < VA + VF + VS),
                   (x < HA && y < VA), 12'(x), 11'(y)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        n_checks++;
        if (obs !== '0 || frame_done !== 1'b0 || frame_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_state: got obs=%h done=%b cnt=%0d expected all zero", obs, frame_done, frame_cnt);
        end
    endtask

    task automatic test_single_frame();
        int de_n = 0, hs_pulses = 0, hs_run = 0, hs_bad = 0, vs_n = 0, busy_n = 0, done_n = 0;
        logic prev_hs = 1'b0;
        frame_trig = 1'b1;
        tick();
        frame_trig = 1'b0;
        for (int k = 0; k < N; k++) begin
            tick();
            n_checks++;
            if (obs !== exp_run(k) || frame_done !== 1'b0) begin
                n_fail++;
                $display("FAIL single_pos%0d: got %h/%b expected %h/0", k, obs, frame_done, exp_run(k));
            end
            de_n   += int'(de_out);
            vs_n   += int'(v_sync_out);
            busy_n += int'(frame_busy);
            done_n += int'(frame_done);
            if (h_sync_out && !prev_hs) hs_pulses++;
            if (h_sync_out) hs_run++;
            else if (hs_run > 0) begin
                if (hs_run != HS) hs_bad++;
                hs_run = 0;
            end
            prev_hs = h_sync_out;
            // Triggers during RUN must be ignored; none may reach the idle edge.
            frame_trig = (k == 9) ? 1'b1 : (k < N - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        frame_trig = 1'b0;
        tick();
        exp_cnt++;
        done_n += int'(frame_done);
        n_checks++;
        if (obs !== '0 || frame_done !== 1'b1 || frame_cnt !== exp_cnt) begin
            n_fail++;
            $display("FAIL single_end: got obs=%h done=%b cnt=%0d expected 0/1/%0d", obs, frame_done, frame_cnt, exp_cnt);
        end
        tick();
        n_checks++;
        if (obs !== '0 || frame_done !== 1'b0 || frame_cnt !== exp_cnt) begin
            n_fail++;
            $display("FAIL single_idle: got obs=%h done=%b cnt=%0d expected 0/0/%0d", obs, frame_done, frame_cnt, exp_cnt);
        end
        n_checks++;
        if (de_n != HA * VA || hs_pulses != VT || hs_bad != 0 || vs_n != HT * VS || busy_n != N || done_n != 1) begin
            n_fail++;
            $display("FAIL single_totals: got de=%0d hs=%0d hsbad=%0d vs=%0d busy=%0d done=%0d expected %0d/%0d/0/%0d/%0d/1",
                     de_n, hs_pulses, hs_bad, vs_n, busy_n, done_n, HA * VA, VT, HT * VS, N);
        end
    endtask

    task automatic test_abort();
        int p;
        for (int r = 0; r < 3; r++) begin
            p = (r == 0) ? 40 : int'($urandom_range(1, N - 2));
            frame_trig = 1'b1;
            tick();
            frame_trig = 1'b0;
            for (int k = 0; k <= p; k++) begin
                tick();
                n_checks++;
                if (obs !== exp_run(k)) begin
                    n_fail++;
                    $display("FAIL abort%0d_pos%0d: got %h expected %h", p, k, obs, exp_run(k));
                end
                abort = (k == p - 1);
            end
            abort = 1'b0;
            tick();
            n_checks++;
            if (obs !== '0 || frame_done !== 1'b0) begin
                n_fail++;
                $display("FAIL abort%0d_stop: got obs=%h done=%b expected 0/0", p, obs, frame_done);
            end
            tick();
            n_checks++;
            if (frame_done !== 1'b0 || frame_cnt !== exp_cnt) begin
                n_fail++;
                $display("FAIL abort%0d_cnt: got done=%b cnt=%0d expected 0/%0d", p, frame_done, frame_cnt, exp_cnt);
            end
        end
        // abort wins over a simultaneous trigger in IDLE
        abort = 1'b1;
        frame_trig = 1'b1;
        tick();
        abort = 1'b0;
        frame_trig = 1'b0;
        tick();
        n_checks++;
        if (obs !== '0) begin
            n_fail++;
            $display("FAIL abort_trig_idle: got %h expected 0", obs);
        end
        // fresh frame starts at (0,0); abort on the final position suppresses done
        frame_trig = 1'b1;
        tick();
        frame_trig = 1'b0;
        for (int k = 0; k < N; k++) begin
            tick();
            n_checks++;
            if (obs !== exp_run(k)) begin
                n_fail++;
                $display("FAIL abortlast_pos%0d: got %h expected %h", k, obs, exp_run(k));
            end
            abort = (k == N - 2);
        end
        abort = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (obs !== '0 || frame_done !== 1'b0 || frame_cnt !== exp_cnt) begin
                n_fail++;
                $display("FAIL abortlast_idle%0d: got obs=%h done=%b cnt=%0d expected 0/0/%0d", i, obs, frame_done, frame_cnt, exp_cnt);
            end
        end
    endtask

    task automatic test_back_to_back();
        frame_trig = 1'b1;
        tick();
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < N; k++) begin
                tick();
                n_checks++;
                if (obs !== exp_run(k) || frame_done !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b_f%0d_pos%0d: got %h/%b expected %h/0", f, k, obs, frame_done, exp_run(k));
                end
                if (f == 2 && k == N - 1) frame_trig = 1'b0;
            end
            tick();
            exp_cnt++;
            n_checks++;
            if (obs !== '0 || frame_done !== 1'b1 || frame_cnt !== exp_cnt) begin
                n_fail++;
                $display("FAIL b2b_gap%0d: got obs=%h done=%b cnt=%0d expected 0/1/%0d", f, obs, frame_done, frame_cnt, exp_cnt);
            end
        end
        tick();
        n_checks++;
        if (obs !== '0 || frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_after: got obs=%h done=%b expected 0/0", obs, frame_done);
        end
    endtask

    task automatic test_reset_mid_run();
        int len;
        len = int'($urandom_range(5, N - 10));
        frame_trig = 1'b1;
        tick();
        frame_trig = 1'b0;
        for (int k = 0; k < len; k++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        exp_cnt = '0;
        n_checks++;
        if (obs !== '0 || frame_done !== 1'b0 || frame_cnt !== exp_cnt) begin
            n_fail++;
            $display("FAIL reset_mid_run: got obs=%h done=%b cnt=%0d expected all zero", obs, frame_done, frame_cnt);
        end
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (obs !== '0 || frame_cnt !== exp_cnt) begin
                n_fail++;
                $display("FAIL reset_idle%0d: got obs=%h cnt=%0d expected 0/0", i, obs, frame_cnt);
            end
        end
    endtask

    task automatic test_free_run();
        frame_trig = 1'b1;
        tick();
        frame_trig = 1'b0;
        for (int k = 0; k < 3 * N; k++) begin
            tick();
            if (k > 0 && k % N == 0) exp_cnt++;
            n_checks++;
            if (obs !== exp_run(k % N) || frame_done !== (k > 0 && k % N == 0) || frame_cnt !== exp_cnt) begin
                n_fail++;
                $display("FAIL free_pos%0d: got %h/%b/%0d expected %h/%b/%0d", k, obs, frame_done, frame_cnt,
                         exp_run(k % N), (k > 0 && k % N == 0), exp_cnt);
            end
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();
        n_checks++;
        if (obs !== '0) begin
            n_fail++;
            $display("FAIL free_abort: got %h expected 0", obs);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        frame_trig = 1'b0;
        abort      = 1'b0;
        #12;
        test_reset();
        rst_n = 1'b1;
`ifdef VTG_FREE_RUN_EN
        test_free_run();
`else
        test_single_frame();
        test_abort();
        test_back_to_back();
`endif
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pat_video_timing_gen.md
# pat_video_timing_gen

Triggered video timing generator that produces `h_sync_out`, `v_sync_out` and `de_out` for exactly one frame per accepted trigger. It sits directly upstream of the pattern fetch stage, which issues `frame_trig` once its pixel buffer is primed, checks `frame_busy`, and consumes the timing signals to index pixels and count lines. Default parameters give 1920x1080 at a 2200x1125 total raster.

## Interface
- `H_ACTIVE`, 1920, active pixels per line
- `H_FP`, 88, horizontal front porch in cycles
- `H_SYNC`, 44, horizontal sync width in cycles
- `H_BP`, 148, horizontal back porch in cycles
- `V_ACTIVE`, 1080, active lines per frame
- `V_FP`, 4, vertical front porch in lines
- `V_SYNC`, 5, vertical sync width in lines
- `V_BP`, 36, vertical back porch in lines

Ports:
- `clk` input 1: single clock, all logic on rising edge
- `rst_n` input 1: reset, asynchronous, active-low
- `frame_trig` input 1: start-of-frame request; sampled only in IDLE
- `abort` input 1: synchronous frame abort
- `frame_busy` output 1: frame in progress
- `h_sync_out` output 1: horizontal sync, active-high
- `v_sync_out` output 1: vertical sync, active-high
- `de_out` output 1: data enable (active region)
- `pix_x` output 12: horizontal position of the current output cycle
- `pix_y` output 11: vertical position of the current output cycle
- `frame_done` output 1: one-cycle pulse at end of frame
- `frame_cnt` output 16: completed-frame count, wraps at 65535

## Operation
- Derived constants: H_TOTAL = sum of the four H terms; V_TOTAL = sum of the four V terms.
- Raster order within a line: active, FP, sync, BP. Frame order: active lines, FP, sync, BP.
- Counters: `h_cnt` runs 0..H_TOTAL-1. `v_cnt` increments when `h_cnt` wraps and runs 0..V_TOTAL-1.
- Decoded outputs:
  - de = (`h_cnt` < H_ACTIVE) and (`v_cnt` < V_ACTIVE)
  - h_sync = `h_cnt` in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC)
  - v_sync = `v_cnt` in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), for whole lines
- Registered outputs: the decodes and `pix_x`/`pix_y` are registered one cycle behind the counters.
- States:
  - IDLE: counters held at 0. `frame_trig`=1 loads counters to 0 and moves to RUN.
  - RUN: counters advance every cycle. At the last position (H_TOTAL-1, V_TOTAL-1), go to IDLE, pulse `frame_done`, and increment `frame_cnt`.
  - `abort`=1 in RUN: go to IDLE on the next edge and clear counters. No `frame_done`, no `frame_cnt` change.
- `frame_trig` during RUN is ignored and not queued.
- `abort` and `frame_trig` in the same IDLE cycle: abort wins, stay IDLE.
- `abort` in the same cycle as the last position: abort wins.

## Timing
- Reset values (asynchronous): state IDLE, counters 0, every output 0, including `frame_cnt`.
- Trigger accepted at edge T; frame length N = H_TOTAL*V_TOTAL.
  - At edge T+1+k the outputs reflect position k, for k = 0..N-1.
  - `de_out` first rises at edge T+1.
  - `frame_busy` rises at edge T+1 and falls at edge T+N+1, together with the registered outputs returning to 0.
- `frame_done` is high for the single cycle following edge T+N+1.
- In IDLE, `h_sync_out`, `v_sync_out`, `de_out` and `frame_busy` are 0; `pix_x`/`pix_y` hold 0.
- With `frame_trig` held high, back-to-back frames are separated by exactly one idle output cycle.
- Abort at edge A: outputs and `frame_busy` are 0 from edge A+1.

## Configuration
- `VTG_FREE_RUN_EN` defined: at the last position, counters wrap to (0,0) and stay in RUN. `frame_busy` stays 1 with no gap. `frame_done` pulses and `frame_cnt` increments on each frame; only `abort` or reset returns the block to IDLE.
- Not defined: single-shot behaviour as above; one frame per accepted trigger.

## Test plan
Use small parameters (H 8/2/2/2 = 14, V 4/1/1/1 = 7, N = 98) unless stated.
- Reset mid-RUN → all outputs 0 immediately, no clock needed; IDLE afterwards.
- Single `frame_trig` pulse → exactly 32 `de_out` cycles, 7 `h_sync_out` pulses of 2 cycles, 1 `v_sync_out` of 14 cycles, `frame_busy` high for 98 cycles, `frame_done` once, `frame_cnt`=1.
- `frame_trig` at cycle 10 of a frame → ignored; frame length still 98, `frame_cnt`=1.
- `abort` at position 40 → outputs 0 next cycle, no `frame_done`, `frame_cnt` unchanged; a new trigger then starts at (0,0).
- `frame_trig` held high for 3 frames → 3 `frame_done`, `frame_cnt`=3, one idle cycle between frames.
- Default parameters with `VTG_FREE_RUN_EN` → `frame_done` every 2,475,000 cycles, `frame_busy` never drops, 1080 lines of 1920 de cycles per frame.
